// File: rtl/event_timestamp_logger.sv
// Change logger: timestamps every change of sig_in and queues {time, value} for a reader.
// Latency: an event sampled at edge n is visible on the read port after edge n; no bypass.
// Backpressure: rd_valid/rd_ready; an event arriving when full without a pop is dropped and sets overflow.

// Generic show-ahead FIFO: registered storage, head driven combinationally from mem[rd_ptr].
// Latency: a write at edge n is readable after edge n. Backpressure: wr_rdy drops when full unless popping.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld && rd_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_rdy = (cnt != FULL_CNT) || pop;
    assign push   = wr_vld && wr_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module event_timestamp_logger #(
    parameter int WIDTH    = 4,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         sig_in,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [TS_WIDTH-1:0]      rd_time,
    output logic [WIDTH-1:0]         rd_value,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [WIDTH-1:0]    value;
    } entry_t;

    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    prev;
    logic                first;
    logic                ev_vld;
    logic                ev_rdy;
    entry_t              ev_dat;
    entry_t              head_dat;

    // The first enabled cycle after reset always logs, giving the reader an initial value.
    assign ev_vld = en && (first || (sig_in != prev));
    assign ev_dat = '{ts: ts, value: sig_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            prev     <= '0;
            first    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                ts    <= ts + 1'b1;
                prev  <= sig_in;
                first <= 1'b0;
            end
            if (ev_vld && !ev_rdy) begin
                overflow <= 1'b1;
            end
        end
    end

    fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (ev_vld),
        .wr_rdy (ev_rdy),
        .wr_dat (ev_dat),
        .rd_vld (rd_valid),
        .rd_rdy (rd_ready),
        .rd_dat (head_dat),
        .cnt    (count)
    );

    assign rd_time  = head_dat.ts;
    assign rd_value = head_dat.value;
endmodule

// File: tb/tb_event_timestamp_logger.sv
// Bench for event_timestamp_logger: a queue model of the FIFO scoreboards every cycle,
// and each scenario checks the entries it drained against its own constant table.
module tb_event_timestamp_logger;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  sig_in = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [15:0] rd_time;
    logic [3:0]  rd_value;
    logic [3:0]  count;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard model state
    logic [19:0] q[$];
    logic [19:0] got[$];
    logic [15:0] m_ts;
    logic [3:0]  m_prev;
    logic        m_first;
    logic        m_ovf;

    event_timestamp_logger #(.WIDTH(4), .TS_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_time  (rd_time),
        .rd_value (rd_value),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // One clock: checks head/count/overflow against the model, applies inputs, updates the model.
    task automatic step(input logic e, input logic [3:0] s, input logic r);
        logic pop;
        logic ev;
        en = e; sig_in = s; rd_ready = r;
        #1;
        vectors++;
        if (rd_valid !== (q.size() != 0)) begin
            miscompares++;
            $display("FAIL step_rd_valid: got %b want %b", rd_valid, q.size() != 0);
        end
        vectors++;
        if (count !== 4'(q.size()) || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL step_count_ovf: got count=%0d ovf=%b want count=%0d ovf=%b",
                     count, overflow, q.size(), m_ovf);
        end
        if (q.size() != 0) begin
            vectors++;
            if ({rd_time, rd_value} !== q[0]) begin
                miscompares++;
                $display("FAIL step_head: got (%0d,%b) want (%0d,%b)",
                         rd_time, rd_value, q[0][19:4], q[0][3:0]);
            end
        end
        pop = r && (q.size() != 0);
        if (pop) begin
            got.push_back({rd_time, rd_value});
            void'(q.pop_front());
        end
        ev = e && (m_first || (s != m_prev));
        if (ev) begin
            if (q.size() < DEPTH) q.push_back({m_ts, s});
            else m_ovf = 1'b1;
        end
        if (e) begin
            m_ts = m_ts + 16'd1;
            m_prev = s;
            m_first = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete(); got.delete();
        m_ts = '0; m_prev = '0; m_first = 1'b1; m_ovf = 1'b0;
    endtask

    task automatic test_reset(input int cycles, input logic e);
        rst = 1'b1; en = e; rd_ready = 1'b0; sig_in = 4'b1001;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b count=%0d ovf=%b want 0/0/0",
                     rd_valid, count, overflow);
        end
    endtask

    task automatic test_sequence();
        int          t[4] = '{0, 5, 10, 20};
        logic [3:0]  v[4] = '{4'b0000, 4'b0001, 4'b0101, 4'b1101};
        logic [3:0]  s;
        test_reset(2, 1'b1);
        for (int c = 0; c <= 20; c++) begin
            s = (c < 5) ? 4'b0000 : (c < 10) ? 4'b0001 : (c < 20) ? 4'b0101 : 4'b1101;
            step(1'b1, s, 1'b0);
        end
        vectors++;
        if (count !== 4'd4) begin
            miscompares++;
            $display("FAIL seq_count: got %0d want 4", count);
        end
        for (int c = 0; c < 7; c++) step(1'b0, 4'b1101, 1'b1);  // extra cycles: ready while empty
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL seq_drain_len: got %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== {16'(t[i]), v[i]}) begin
                miscompares++;
                $display("FAIL seq_entry%0d: got (%0d,%b) want (%0d,%b)",
                         i, got[i][19:4], got[i][3:0], t[i], v[i]);
            end
        end
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_empty: got rd_valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_constant();
        test_reset(2, 1'b0);
        for (int c = 0; c < 50; c++) step(1'b1, 4'b1010, 1'b0);
        vectors++;
        if (count !== 4'd1) begin
            miscompares++;
            $display("FAIL const_count: got %0d want 1", count);
        end
        step(1'b0, 4'b1010, 1'b1);
        vectors++;
        if (got.size() != 1 || got[0] !== {16'd0, 4'b1010}) begin
            miscompares++;
            $display("FAIL const_entry: got n=%0d first=%h want n=1 first=0000a",
                     got.size(), (got.size() != 0) ? got[0] : 20'h0);
        end
    endtask

    task automatic test_enable_gap();
        test_reset(2, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 4'b0111, 1'b0);
        vectors++;
        if (count !== 4'd2) begin
            miscompares++;
            $display("FAIL gap_frozen_count: got %0d want 2", count);
        end
        step(1'b1, 4'b0111, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 4'b0111, 1'b1);
        vectors++;
        if (got.size() != 3 || got[1] !== {16'd3, 4'b0011} || got[2] !== {16'd4, 4'b0111}) begin
            miscompares++;
            $display("FAIL gap_entries: got n=%0d e1=%h e2=%h want n=3 e1=00033 e2=00047",
                     got.size(), (got.size() > 1) ? got[1] : 20'h0,
                     (got.size() > 2) ? got[2] : 20'h0);
        end
    endtask

    task automatic test_overflow();
        test_reset(2, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b1, (c % 2 == 0) ? 4'b0101 : 4'b1010, 1'b0);
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_full: got count=%0d ovf=%b want 8/1", count, overflow);
        end
        for (int c = 0; c < 9; c++) step(1'b0, 4'b1010, 1'b1);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= got.size() || got[i][19:4] !== 16'(i)) begin
                miscompares++;
                $display("FAIL ovf_ts%0d: got %0d want %0d", i,
                         (i < got.size()) ? got[i][19:4] : 16'hffff, i);
            end
        end
        vectors++;
        if (overflow !== 1'b1 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_sticky: got ovf=%b valid=%b want 1/0", overflow, rd_valid);
        end
    endtask

    task automatic test_back_to_back();
        test_reset(2, 1'b0);
        for (int c = 0; c < 8; c++) step(1'b1, (c % 2 == 0) ? 4'b0001 : 4'b0010, 1'b0);
        for (int c = 8; c < 14; c++) begin
            step(1'b1, (c % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1);
            vectors++;
            if (count !== 4'd8 || overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_full_pop c%0d: got count=%0d ovf=%b want 8/0", c, count, overflow);
            end
        end
        for (int c = 0; c < 9; c++) step(1'b0, 4'b0010, 1'b1);
        vectors++;
        if (got.size() != 14) begin
            miscompares++;
            $display("FAIL b2b_len: got %0d want 14", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i][19:4] !== 16'(i)) begin
                miscompares++;
                $display("FAIL b2b_ts%0d: got %0d want %0d", i, got[i][19:4], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        test_reset(2, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b1, 4'(c + 1), 1'b0);
        vectors++;
        if (count !== 4'd5) begin
            miscompares++;
            $display("FAIL mid_count: got %0d want 5", count);
        end
        test_reset(1, 1'b1);
        step(1'b1, 4'b1111, 1'b0);
        vectors++;
        if (rd_valid !== 1'b1 || rd_time !== 16'd0 || rd_value !== 4'b1111) begin
            miscompares++;
            $display("FAIL mid_first_log: got valid=%b (%0d,%b) want 1 (0,1111)",
                     rd_valid, rd_time, rd_value);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_sequence();
        test_constant();
        test_enable_gap();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/event_timestamp_logger.md
Name: event_timestamp_logger

Overview:
- Records *when* a group of signals changes, so timed event sequences produced by the block's stimulus generators can be checked cycle-accurately.
- Samples a WIDTH-bit input vector every enabled cycle and detects any change.
- On each change, pushes a {timestamp, value} entry into an internal FIFO.
- The FIFO is drained through a valid/ready read port by a checker or host.

Parameters:
- WIDTH, 4: width of the monitored input vector.
- TS_WIDTH, 16: width of the free-running timestamp counter.
- DEPTH, 8: number of FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  input  1  — single clock; all logic on rising edge.
- rst  input  1  — synchronous, active-high reset.
- en  input  1  — sampling enable; when low, the timestamp freezes and nothing is logged.
- sig_in  input  WIDTH  — monitored vector.
- rd_valid  output  1  — FIFO head holds a valid entry.
- rd_ready  input  1  — consumer accepts the head entry this cycle.
- rd_time  output  TS_WIDTH  — timestamp of the head entry.
- rd_value  output  WIDTH  — sig_in value of the head entry.
- count  output  log2(DEPTH)+1  — number of entries currently stored.
- overflow  output  1  — sticky flag: at least one event was dropped.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - ts=0, prev=0, first=1, wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: rd_valid=0; rd_time and rd_value are don't-care while rd_valid=0 (bench must not check them).
  - Reset takes priority over every other event in the same cycle; FIFO contents are discarded.
- Timestamp counter:
  - ts increments by 1 on each clock where en=1.
  - Wraps modulo 2^TS_WIDTH with no flag.
  - The entry time is the ts value *before* increment in the sampling cycle. The first enabled cycle after reset is time 0.
- Event detection (push request):
  - Raised in a cycle when en=1 and either (first=1) or (sig_in != prev).
  - When en=1: prev <= sig_in and first <= 0.
  - When en=0: prev, first and ts hold.
  - On re-enable, sig_in is compared against the held prev. No forced log on re-enable; the forced log happens only on the first enabled cycle after reset.
- Push: writes {ts, sig_in} at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop: occurs when rd_valid && rd_ready; rd_ptr increments modulo DEPTH.
- Read port is show-ahead:
  - rd_valid = (count != 0).
  - rd_time and rd_value are driven combinationally from mem[rd_ptr].
- Latency: an event sampled at edge n is visible on rd_valid/rd_time/rd_value after edge n (registered). There is no same-cycle bypass.
- Boundary conditions:
  - Push while full with no pop: entry dropped; overflow <= 1 (sticky until reset); count stays DEPTH; wr_ptr unchanged.
  - Push while full with a simultaneous pop: push accepted; count stays DEPTH; no overflow.
  - Push and pop in the same cycle when not full: both occur; count unchanged.
  - rd_ready while empty: ignored; pointers unchanged.
  - rd_valid and head data must remain stable while rd_valid=1 and rd_ready=0.
  - An event recorded after a timestamp wrap carries the wrapped value; no special handling.
- Counting: count changes by +1 on push-only, −1 on pop-only, 0 on both or neither. It never exceeds DEPTH and never underflows.

Test Plan:
- Sequence test, starting from reset:
  - Stimulus: rst for 2 cycles, then en=1 with rd_ready=0. sig_in=0000 at enabled cycle 0, 0001 at cycle 5, 0101 at cycle 10, 1101 at cycle 20.
  - Required response: count=4. Drain with rd_ready=1 → entries (0,0000), (5,0001), (10,0101), (20,1101) in that order; rd_valid then 0.
- Constant input: hold sig_in=1010 for 50 cycles after reset → exactly one entry (0,1010); count stays 1.
- Enable gap:
  - Stimulus: change sig_in to 0011 at cycle 3. Drop en for 10 cycles and change sig_in to 0111 while disabled. Re-enable.
  - Required response: entry (3,0011), then entry (4,0111) on the first re-enabled cycle.
- Overflow (DEPTH=8):
  - Stimulus: toggle sig_in every cycle for 10 cycles with rd_ready=0.
  - Required response: count=8, overflow=1; drained entries carry timestamps 0..7; overflow stays 1 after the drain.
- Full with simultaneous pop:
  - Stimulus: fill to 8, then assert rd_ready=1 while toggling continues.
  - Required response: count holds at 8, overflow stays 0, timestamps are contiguous.
- Reset mid-operation: assert rst with 5 entries stored → next cycle rd_valid=0, count=0, overflow=0; the next enabled cycle logs at time 0.
